// File: rtl/mult_div_unit_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_unit_pkg
// Shared constants for the multiply/divide unit: the 3-bit md_op encodings
// used by the decoder, the arithmetic core and the HI/LO control logic.
// Codes 6 and 7 are no-ops.
// -----------------------------------------------------------------------------
package mult_div_unit_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    // True for the ops that occupy the unit for several cycles.
    function automatic logic is_multi_cycle(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_core.sv
// -----------------------------------------------------------------------------
// md_core
// Purely combinational multiply/divide datapath.
//   in0    : rs operand (multiplicand / dividend)
//   in1    : rt operand (multiplier / divisor)
//   md_op  : operation code (mult_div_unit_pkg encodings)
//   res_hi : product upper half, or division remainder
//   res_lo : product lower half, or division quotient
// Division by zero returns hi = dividend, lo = all ones. The signed overflow
// case (most negative / -1) returns lo = most negative, hi = 0.
// Non-arithmetic op codes produce zero.
// -----------------------------------------------------------------------------
module md_core
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [2:0]       md_op,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [2*WIDTH-1:0] ext0_s;
    logic signed [2*WIDTH-1:0] ext1_s;
    logic signed [2*WIDTH-1:0] prod_s;
    logic        [2*WIDTH-1:0] prod_u;

    logic [WIDTH-1:0] mag0;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] sdiv_den;
    logic [WIDTH-1:0] udiv_den;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] q_u;
    logic [WIDTH-1:0] r_u;
    logic             neg0;
    logic             neg1;

    // Sign-extending to double width makes the truncated double-width
    // product equal to the exact signed product.
    assign ext0_s = $signed({{WIDTH{in0[WIDTH-1]}}, in0});
    assign ext1_s = $signed({{WIDTH{in1[WIDTH-1]}}, in1});
    assign prod_s = ext0_s * ext1_s;
    assign prod_u = {{WIDTH{1'b0}}, in0} * {{WIDTH{1'b0}}, in1};

    // Signed division runs on magnitudes, then signs are restored:
    // quotient negative when operand signs differ, remainder follows dividend.
    assign neg0 = in0[WIDTH-1];
    assign neg1 = in1[WIDTH-1];
    assign mag0 = neg0 ? ('0 - in0) : in0;
    assign mag1 = neg1 ? ('0 - in1) : in1;

    // Zero divisors are replaced by 1 so the dividers never see x/0;
    // the real zero-divisor result is substituted below.
    assign sdiv_den = (mag1 == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag1;
    assign udiv_den = (in1  == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : in1;

    assign q_mag = mag0 / sdiv_den;
    assign r_mag = mag0 % sdiv_den;
    assign q_u   = in0 / udiv_den;
    assign r_u   = in0 % udiv_den;

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (md_op)
            MD_MULT: begin
                res_hi = prod_s[2*WIDTH-1:WIDTH];
                res_lo = prod_s[WIDTH-1:0];
            end
            MD_MULTU: begin
                res_hi = prod_u[2*WIDTH-1:WIDTH];
                res_lo = prod_u[WIDTH-1:0];
            end
            MD_DIV: begin
                if (in1 == '0) begin
                    res_hi = in0;
                    res_lo = '1;
                end else if ((in0 == MOST_NEG) && (in1 == '1)) begin
                    res_hi = '0;
                    res_lo = MOST_NEG;
                end else begin
                    res_lo = (neg0 ^ neg1) ? ('0 - q_mag) : q_mag;
                    res_hi = neg0 ? ('0 - r_mag) : r_mag;
                end
            end
            MD_DIVU: begin
                if (in1 == '0) begin
                    res_hi = in0;
                    res_lo = '1;
                end else begin
                    res_hi = r_u;
                    res_lo = q_u;
                end
            end
            default: begin
                res_hi = '0;
                res_lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Multi-cycle multiply/divide unit with HI/LO result registers (EX stage).
// The full result is computed combinationally on the accept edge and parked
// in pending registers; only the commit to HI/LO is delayed by the op latency.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; aborts any op in flight
//   start : one-cycle request, accepted when busy is low
//   md_op : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   in0   : rs operand (multiplicand / dividend / MTHI-MTLO data)
//   in1   : rt operand (multiplier / divisor)
//   busy  : MUL_CYCLES or DIV_CYCLES cycles after a MULT*/DIV* accept
//   hi    : HI register
//   lo    : LO register
// -----------------------------------------------------------------------------
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] pend_hi_p1;
    logic [WIDTH-1:0] pend_lo_p1;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    md_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .in0    (in0),
        .in1    (in1),
        .md_op  (md_op),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    assign accept = start && !busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy       <= 1'b0;
            cnt        <= '0;
            hi         <= '0;
            lo         <= '0;
            pend_hi_p1 <= '0;
            pend_lo_p1 <= '0;
        end else if (busy) begin
            // Counter reaching zero marks the last busy cycle: commit now.
            if (cnt == '0) begin
                hi   <= pend_hi_p1;
                lo   <= pend_lo_p1;
                busy <= 1'b0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end else if (accept) begin
            // Accept -> pending registers (p1); commit to HI/LO after latency.
            if (is_multi_cycle(md_op)) begin
                pend_hi_p1 <= res_hi;
                pend_lo_p1 <= res_lo;
                busy       <= 1'b1;
                cnt        <= ((md_op == MD_MULT) || (md_op == MD_MULTU)) ? MUL_LOAD : DIV_LOAD;
            end else if (md_op == MD_MTHI) begin
                hi <= in0;
            end else if (md_op == MD_MTLO) begin
                lo <= in0;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
// Self-checking bench for mult_div_unit (WIDTH=32, MUL_CYCLES=5,
// DIV_CYCLES=10): directed corner cases followed by randomized ops compared
// against a plain-arithmetic reference model of HI/LO and op latency.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

    localparam int W    = 32;
    localparam int MULC = 5;
    localparam int DIVC = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   md_op;
    logic [W-1:0] in0;
    logic [W-1:0] in1;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int tests  = 0;
    int failed = 0;
    int start_while_busy = 0;

    // Reference model state
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    always #5 clk = ~clk;

    mult_div_unit #(
        .WIDTH      (W),
        .MUL_CYCLES (MULC),
        .DIV_CYCLES (DIVC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .in0   (in0),
        .in1   (in1),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    // Counts start requests that arrive while the unit is busy; the pipeline
    // never does this, so only the deliberate directed case should hit it.
    always @(posedge clk) begin
        if (start && busy && !reset) start_while_busy++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: result from the arithmetic definition, latency from op class.
    function automatic void ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   inout logic [W-1:0] h, inout logic [W-1:0] l, output int lat);
        longint          ps;
        longint unsigned pu;
        int              sa;
        int              sb;
        sa  = $signed(a);
        sb  = $signed(b);
        lat = 0;
        case (op)
            3'd0: begin
                ps = longint'(sa) * longint'(sb);
                {h, l} = ps;
                lat = MULC;
            end
            3'd1: begin
                pu = 64'(a) * 64'(b);
                {h, l} = pu;
                lat = MULC;
            end
            3'd2: begin
                if (b == 0) begin
                    h = a;
                    l = 32'hFFFF_FFFF;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    h = 0;
                    l = 32'h8000_0000;
                end else begin
                    l = 32'(sa / sb);
                    h = 32'(sa % sb);
                end
                lat = DIVC;
            end
            3'd3: begin
                if (b == 0) begin
                    h = a;
                    l = 32'hFFFF_FFFF;
                end else begin
                    l = a / b;
                    h = a % b;
                end
                lat = DIVC;
            end
            3'd4: h = a;
            3'd5: l = a;
            default: ;
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        md_op = op;
        in0   = a;
        in1   = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts busy cycles (starting from n0 already seen), checks HI/LO hold
    // while busy, then checks latency and final HI/LO against the model.
    task automatic wait_done(input string tag, input int n0, input int lat,
                             input logic [W-1:0] old_h, input logic [W-1:0] old_l);
        int n;
        n = n0;
        while (busy && n < 60) begin
            check_eq({tag, " hold"}, {hi, lo}, {old_h, old_l});
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, " latency"}, 64'(n), 64'(lat));
        check_eq({tag, " hi"}, 64'(hi), 64'(m_hi));
        check_eq({tag, " lo"}, 64'(lo), 64'(m_lo));
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] old_h;
        logic [W-1:0] old_l;
        int           lat;
        old_h = m_hi;
        old_l = m_lo;
        ref_op(op, a, b, m_hi, m_lo, lat);
        issue(op, a, b);
        wait_done(tag, 0, lat, old_h, old_l);
    endtask

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [W-1:0] old_h;
        logic [W-1:0] old_l;
        int           lat;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;

        reset = 1'b1;
        start = 1'b0;
        md_op = 3'd0;
        in0   = '0;
        in1   = '0;
        m_hi  = '0;
        m_lo  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset busy", 64'(busy), 64'd0);
        check_eq("reset hi", 64'(hi), 64'd0);
        check_eq("reset lo", 64'(lo), 64'd0);

        // Reset takes priority over a simultaneous start.
        issue(3'd4, 32'hAAAA, 32'd0);
        check_eq("reset overrides start hi", 64'(hi), 64'd0);
        reset = 1'b0;

        // 1. multiply sign handling
        run_op("mult", 3'd0, 32'hFFFF_FFFF, 32'd2);
        check_eq("mult hi const", 64'(hi), 64'hFFFF_FFFF);
        check_eq("mult lo const", 64'(lo), 64'hFFFF_FFFE);
        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2);
        check_eq("multu hi const", 64'(hi), 64'h1);
        check_eq("multu lo const", 64'(lo), 64'hFFFF_FFFE);

        // 2. division rounding and remainder sign
        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2);
        check_eq("div lo const", 64'(lo), 64'hFFFF_FFFD);
        check_eq("div hi const", 64'(hi), 64'hFFFF_FFFF);
        run_op("divu", 3'd3, 32'd7, 32'd2);
        check_eq("divu lo const", 64'(lo), 64'd3);
        check_eq("divu hi const", 64'(hi), 64'd1);

        // 3. divide by zero and signed overflow
        run_op("div0", 3'd2, 32'd5, 32'd0);
        check_eq("div0 hi const", 64'(hi), 64'd5);
        check_eq("div0 lo const", 64'(lo), 64'hFFFF_FFFF);
        run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check_eq("divovf lo const", 64'(lo), 64'h8000_0000);
        check_eq("divovf hi const", 64'(hi), 64'd0);

        // 4. MTHI then MTLO back to back, never busy
        run_op("mthi", 3'd4, 32'h1234, 32'd0);
        run_op("mtlo", 3'd5, 32'h5678, 32'd0);
        check_eq("mthi hi const", 64'(hi), 64'h1234);
        check_eq("mtlo lo const", 64'(lo), 64'h5678);

        // Start during MULT busy is ignored.
        old_h = m_hi;
        old_l = m_lo;
        ref_op(3'd0, 32'd6, 32'hFFFF_FFFD, m_hi, m_lo, lat);
        issue(3'd0, 32'd6, 32'hFFFF_FFFD);
        check_eq("busy after accept", 64'(busy), 64'd1);
        @(posedge clk); #1;
        issue(3'd3, 32'd100, 32'd7);
        wait_done("mult ignore", 2, lat, old_h, old_l);
        check_eq("start while busy seen", 64'(start_while_busy), 64'd1);

        // 5. reset during the third busy cycle aborts the op
        issue(3'd0, 32'd3, 32'd4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("abort busy cycle3", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        check_eq("abort busy", 64'(busy), 64'd0);
        check_eq("abort hi", 64'(hi), 64'd0);
        check_eq("abort lo", 64'(lo), 64'd0);
        repeat (12) @(posedge clk);
        #1;
        check_eq("abort no commit", {31'd0, busy, hi}, 64'd0);
        check_eq("abort no commit lo", 64'(lo), 64'd0);

        // 6. random ops; successive run_op calls start on the busy-fall cycle
        for (int i = 0; i < 1000; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = rand_opnd();
            b  = rand_opnd();
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            run_op($sformatf("rand%0d op%0d", i, op), op, a, b);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
